// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding unit.
// The entry record carries a destination field sized for the widest supported
// register number; narrower register files zero-extend into it.
package pipe_pkg;

    localparam int REG_AW_DEF     = 5;
    localparam int DEPTH_DEF      = 3;
    localparam int LOAD_STAGE_DEF = 2;

    // Upper bound on REG_AW that the shared record can hold.
    localparam int REG_AW_MAX     = 8;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                  valid;
        logic                  wreg;
        logic                  m2reg;
        logic [REG_AW_MAX-1:0] d;
    } pipe_entry_t;

    // Width of a forward select able to name stages 0..depth.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_src_match.sv
// Youngest-producer search for one ID source register over the tracked
// record. Returns whether any in-flight writer matches, which stage holds the
// youngest one, and whether that producer is a load.
module pipe_src_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SW     = sel_width(DEPTH)
) (
    input  logic [REG_AW-1:0]       src,
    input  logic                    use_src,
    input  pipe_entry_t [DEPTH:1]   rec,
    output logic                    hit,
    output logic [SW-1:0]           stage,
    output logic                    is_load
);

    // Walk from the oldest stage towards EXE so a younger match overwrites an
    // older one; register 0 and unused sources never match.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (use_src && (src != '0) && rec[k].valid && rec[k].wreg &&
                (rec[k].d == REG_AW_MAX'(src))) begin
                hit     = 1'b1;
                stage   = SW'(k);
                is_load = rec[k].m2reg;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding beside the ID stage.
// Tracks {valid, wreg, m2reg, d} for stages 1 (EXE) .. DEPTH, drives the
// forward selects and the stall, and counts stalled cycles (saturating).
// Build option: define PIPE_FORWARD_EN to enable forwarding. When it is not
// defined the selects stay 0 and any dependency on a tracked stage stalls
// until the producer has left the record.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int CNT_W      = 32,
    parameter int SW         = sel_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [REG_AW-1:0] id_d,
    output logic              stall,
    output logic [SW-1:0]     fwd_a,
    output logic [SW-1:0]     fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    pipe_entry_t [DEPTH:1] rec;
    pipe_entry_t           id_entry;

    logic          hit_a, hit_b;
    logic          load_a, load_b;
    logic [SW-1:0] stage_a, stage_b;
    logic          luse_a, luse_b;
    logic          load_use, any_dep;

    pipe_src_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SW(SW)) u_match_rs (
        .src     (id_rs),
        .use_src (id_use_rs),
        .rec     (rec),
        .hit     (hit_a),
        .stage   (stage_a),
        .is_load (load_a)
    );

    pipe_src_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SW(SW)) u_match_rt (
        .src     (id_rt),
        .use_src (id_use_rt),
        .rec     (rec),
        .hit     (hit_b),
        .stage   (stage_b),
        .is_load (load_b)
    );

    // Classify each source's youngest producer and derive stall and selects.
    always_comb begin
        luse_a   = hit_a && load_a && (stage_a < SW'(LOAD_STAGE));
        luse_b   = hit_b && load_b && (stage_b < SW'(LOAD_STAGE));
        load_use = id_valid && (luse_a || luse_b);
        any_dep  = id_valid && (hit_a || hit_b);
        stall    = FWD_EN ? load_use : any_dep;
        fwd_a    = (FWD_EN && hit_a && !luse_a) ? stage_a : '0;
        fwd_b    = (FWD_EN && hit_b && !luse_b) ? stage_b : '0;
    end

    // What ID hands to EXE: the real instruction, or a bubble when stalled.
    always_comb begin
        id_entry       = '0;
        id_entry.valid = id_valid && !stall;
        id_entry.wreg  = id_wreg;
        id_entry.m2reg = id_m2reg;
        id_entry.d     = REG_AW_MAX'(id_d);
        if (!id_entry.valid) begin
            id_entry = '0;
        end
    end

    // Advance the in-flight record one stage per clock; the oldest drops off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the record is a handful of flops, so it is cleared by reset; only valid matters but zeroing all is cheapest to reason about.
            rec <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                // NOTE: non-blocking so each stage takes its neighbour's old value.
                rec[k] <= rec[k-1];
            end
            rec[1] <= id_entry;
        end
    end

    // Count stalled cycles, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the five-stage pipelined CPU, sitting beside the ID stage. It records the destination register, write-enable and load flag of every instruction in flight from EXE up to the last stage before register-file write. It compares the ID-stage source registers against that record and produces the operand-forwarding selects and the load-use stall. It also converts stalled cycles into EXE bubbles and counts them. Tracked depth and the stage where load data becomes available are parameters, so deeper pipelines reuse the block.

## Interface
- REG_AW, 5, register-number width
- DEPTH, 3, tracked stages after ID (1 = EXE … DEPTH = last before register-file write)
- LOAD_STAGE, 2, first stage index at which load data is forwardable; 1 ≤ LOAD_STAGE ≤ DEPTH
- CNT_W, 32, stall-counter width
- SW, derived = $clog2(DEPTH+1), forward-select width

- Clock  in  1  rising-edge clock, the only clock
- Resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW each  ID source register numbers
- id_use_rs, id_use_rt  in  1 each  instruction reads that source
- id_wreg  in  1  ID instruction writes a register
- id_m2reg  in  1  ID instruction is a load
- id_d  in  REG_AW  ID destination register
- stall  out  1  freeze PC and IF/ID; insert bubble into EXE
- fwd_a, fwd_b  out  SW each  0 = register file, k = result of tracked stage k
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Record: DEPTH entries {valid, wreg, m2reg, d}; entry k describes the instruction currently in stage k.
- Every rising edge: entry k+1 ← entry k for k = 1…DEPTH-1; entry DEPTH is dropped.
- Entry 1 loads ID fields when id_valid=1 and stall=0. Otherwise it loads a bubble with valid=0.
- A match at stage k for source s requires all of: valid, wreg, d == s, s ≠ 0, and use_s=1.
- Forwarding is per source: take the smallest k with a match, so the youngest producer wins. The select is k if m2reg=0 or k ≥ LOAD_STAGE, and 0 if there is no match.
- Load-use hazard: the youngest match has m2reg=1 and k < LOAD_STAGE. stall=1 for that cycle. The forward select for that source is don't-care, and the block drives 0.
- stall is qualified by id_valid. A bubble in ID never stalls.
- stall_cnt increments on each edge where stall=1 and saturates at all-ones.
- Register 0 is never matched. A write to $0 is harmless.

## Timing
- stall, fwd_a and fwd_b are combinational from the registered record plus the current ID inputs. They must settle within the same cycle.
- Record and counter update on the rising edge only.
- Reset, asynchronous, at any time:
  - all entries go invalid;
  - stall_cnt goes to 0;
  - hence stall=0 and fwd_a=fwd_b=0 immediately.
- Reset mid-stall: the stall drops immediately and no bubble is recorded.
- Load-use with LOAD_STAGE=2 gives exactly one stall cycle. On the next cycle the load sits in stage 2 and the select is 2.
- Back-to-back loads to the same register: each consumer resolves against the youngest producer only.
- A stage-DEPTH producer is still forwarded. Once dropped, the register file is assumed to be written, with write-before-read in the same cycle.

## Configuration
- PIPE_FORWARD_EN defined: behaviour exactly as above.
- PIPE_FORWARD_EN undefined:
  - fwd_a and fwd_b are tied to 0;
  - stall=1 whenever any tracked stage matches either used source, load or not;
  - the stall repeats until no match remains, so a dependency on EXE costs DEPTH stall cycles;
  - the stall counter is unchanged.

## Structure
- Shared package pipe_pkg holds:
  - the entry record typedef {valid, wreg, m2reg, d};
  - default REG_AW/DEPTH/LOAD_STAGE constants;
  - a function giving the select width.
- One sub-module is natural: pipe_src_match. It takes one source plus the record and returns {hit, stage, is_load} for the youngest match. It is instantiated twice, for rs and rt.

## Test plan
Unless stated, tests use the default parameters.
- Reset: assert Resetn=0 with entries populated → stall=0, fwd_a=fwd_b=0, stall_cnt=0 in the same cycle.
- ALU chain: add $3 in ID, then sub reading $3 next cycle → fwd_a=1. One cycle later another reader → fwd_a=2. Then fwd_a=3. Then 0.
- Load-use: lw $5, then add reading $5 as rt → stall=1 for one cycle, EXE bubble, then fwd_b=2. stall_cnt=1.
- Youngest wins: add $4 followed by or $4, then a reader of $4 → select 1, not 2.
- Register 0 and use flags: a producer of $0 and a reader of $0 → fwd=0, no stall. A reader with id_use_rs=0 whose rs matches → fwd_a=0.
- PIPE_FORWARD_EN undefined: add $3 followed immediately by a reader of $3 → stall=1 for 3 consecutive cycles, then fwd=0 and the reader proceeds. stall_cnt=3.
